// File: rtl/flash_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flash_port_arbiter
//  Description : Shares one spixpress SPI-flash Wishbone reader between two
//                Wishbone-classic read requesters. Round-robin grant, a
//                one-entry last-word read cache and a slave-ack timeout that
//                converts a hung flash read into a bus error pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AW         word-address width
//    TIMEOUT    WAIT cycles without slave ack before an error is returned
//    OPT_CACHE  1 = one-entry read cache enabled, 0 = always read flash
//  Ports
//    clk, rst            clock, synchronous active-low reset
//    m0_* / m1_*         requester ports: cyc, stb, addr in;
//                        stall (combinational), ack, err, data out
//    inval               1-cycle pulse, invalidates the cached word
//    s_cyc/stb/addr/sel  request to spixpress
//    s_stall/ack/data    response from spixpress
// ============================================================================
module flash_port_arbiter #(
    parameter int AW        = 22,
    parameter int TIMEOUT   = 4095,
    parameter bit OPT_CACHE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_stall,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [31:0]   m0_data,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic [AW-1:0] m1_addr,
    output logic          m1_stall,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [31:0]   m1_data,
    input  logic          inval,
    output logic          s_cyc,
    output logic          s_stb,
    output logic [AW-1:0] s_addr,
    output logic [3:0]    s_sel,
    input  logic          s_stall,
    input  logic          s_ack,
    input  logic [31:0]   s_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Last counter value at which an ack is still accepted; one edge later
    // the read is declared dead.
    localparam logic [11:0] c_TMO_LAST = 12'(TIMEOUT - 1);

    state_t        r_state;
    logic          r_rr;        // port favoured when both request
    logic          r_port;      // port owning the current transaction
    logic [AW-1:0] r_addr;
    logic          r_abort;     // owner dropped cyc after acceptance
    logic [11:0]   r_tmo;
    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [31:0]   r_cdata;
    logic [31:0]   r_data;

    logic          w_req0;
    logic          w_req1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_idle;
    logic [AW-1:0] w_addr;
    logic          w_hit;
    logic          w_dead;

    assign w_req0 = m0_cyc & m0_stb;
    assign w_req1 = m1_cyc & m1_stb;
    assign w_gnt0 = w_req0 & (~w_req1 | ~r_rr);
    assign w_gnt1 = w_req1 & (~w_req0 |  r_rr);
    assign w_idle = rst & (r_state == S_IDLE);
    assign w_addr = w_gnt1 ? m1_addr : m0_addr;
    assign w_hit  = OPT_CACHE && r_valid && (r_tag == w_addr);

    // A response is suppressed if the owner let go of cyc at any point,
    // including the very edge the response is generated on.
    assign w_dead = r_abort | ~(r_port ? m1_cyc : m0_cyc);

    assign m0_stall = ~(w_idle & w_gnt0);
    assign m1_stall = ~(w_idle & w_gnt1);
    assign m0_data  = r_data;
    assign m1_data  = r_data;
    assign s_sel    = {4{s_cyc}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_port  <= 1'b0;
            r_addr  <= '0;
            r_abort <= 1'b0;
            r_tmo   <= '0;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_cdata <= '0;
            r_data  <= '0;
            m0_ack  <= 1'b0;
            m0_err  <= 1'b0;
            m1_ack  <= 1'b0;
            m1_err  <= 1'b0;
            s_cyc   <= 1'b0;
            s_stb   <= 1'b0;
            s_addr  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;

            if (inval) begin
                r_valid <= 1'b0;
            end

            if ((r_state == S_ISSUE || r_state == S_WAIT) && w_dead) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_port  <= w_gnt1;
                        r_rr    <= ~w_gnt1;
                        r_addr  <= w_addr;
                        r_abort <= 1'b0;
                        if (w_hit) begin
                            r_data  <= r_cdata;
                            m0_ack  <= ~w_gnt1;
                            m1_ack  <= w_gnt1;
                            r_state <= S_RESP;
                        end else begin
                            s_cyc   <= 1'b1;
                            s_stb   <= 1'b1;
                            s_addr  <= w_addr;
                            r_tmo   <= '0;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!s_stall) begin
                        s_stb   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (s_ack) begin
                        s_cyc   <= 1'b0;
                        r_data  <= s_data;
                        r_cdata <= s_data;
                        r_tag   <= r_addr;
                        r_valid <= ~inval;
                        m0_ack  <= ~w_dead & ~r_port;
                        m1_ack  <= ~w_dead &  r_port;
                        r_state <= S_RESP;
                    end else if (r_tmo >= c_TMO_LAST) begin
                        s_cyc   <= 1'b0;
                        m0_err  <= ~w_dead & ~r_port;
                        m1_err  <= ~w_dead &  r_port;
                        r_state <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 12'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_port_arbiter
//  Description : Self-checking bench for flash_port_arbiter. Directed
//                scenarios followed by randomized reads, all checked against
//                a transaction-level model of cache, round-robin and flash.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flash_port_arbiter;

    localparam int AW  = 22;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic          m0_stall, m0_ack, m0_err;
    logic [31:0]   m0_data;
    logic          m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic          m1_stall, m1_ack, m1_err;
    logic [31:0]   m1_data;
    logic          inval = 1'b0;
    logic          s_cyc, s_stb;
    logic [AW-1:0] s_addr;
    logic [3:0]    s_sel;
    logic          s_stall = 1'b0, s_ack = 1'b0;
    logic [31:0]   s_data = '0;

    always #5 clk = ~clk;

    flash_port_arbiter #(.AW(AW), .TIMEOUT(TMO), .OPT_CACHE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_addr(m0_addr),
        .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_err(m0_err), .m0_data(m0_data),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_addr(m1_addr),
        .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_err(m1_err), .m1_data(m1_data),
        .inval(inval),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_addr(s_addr), .s_sel(s_sel),
        .s_stall(s_stall), .s_ack(s_ack), .s_data(s_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cached word, last accepted port, flash contents.
    bit            mdl_valid = 1'b0;
    logic [AW-1:0] mdl_tag   = '0;
    logic [31:0]   mdl_data  = '0;
    int            last_port = 1;   // port 0 is favoured out of reset
    logic [31:0]   flash_mem [logic [AW-1:0]];

    function automatic logic [31:0] flash_word(input logic [AW-1:0] a);
        if (flash_mem.exists(a)) return flash_mem[a];
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? m0_ack : m1_ack;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? m0_err : m1_err;
    endfunction
    function automatic logic stall_of(input int p);
        return (p == 0) ? m0_stall : m1_stall;
    endfunction
    function automatic logic [31:0] data_of(input int p);
        return (p == 0) ? m0_data : m1_data;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic cyc, input logic stb, input logic [AW-1:0] a);
        if (p == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_addr = a;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_addr = a;
        end
    endtask

    task automatic pulse_inval();
        inval = 1'b1;
        @(posedge clk); #1;
        inval = 1'b0;
        mdl_valid = 1'b0;
    endtask

    // One complete read by port p; called with the DUT idle.
    task automatic read_txn(input int p, input logic [AW-1:0] a, input int stall_n,
                            input int ack_dly, input bit abort, input bit never_ack,
                            input bit inval_at_ack);
        bit          hit;
        logic [31:0] w;
        int          waits;
        bit          done;
        hit = mdl_valid && (mdl_tag == a);
        w   = flash_word(a);
        drive_port(p, 1'b1, 1'b1, a);
        #1;
        check("grant_stall", 32'(stall_of(p)), 32'd0);
        check("other_stall", 32'(stall_of(1 - p)), 32'd1);
        @(posedge clk); #1;
        last_port = p;
        drive_port(p, 1'b1, 1'b0, a);
        if (hit) begin
            check("hit_ack", 32'(ack_of(p)), 32'd1);
            check("hit_data", data_of(p), mdl_data);
            check("hit_no_flash", 32'(s_cyc), 32'd0);
        end else begin
            check("issue_bus", 32'({s_cyc, s_stb, s_sel}), 32'h3F);
            check("issue_addr", 32'(s_addr), 32'(a));
            check("no_early_ack", 32'(ack_of(p)), 32'd0);
            s_stall = (stall_n > 0);
            for (int i = 0; i < stall_n; i++) begin
                @(posedge clk); #1;
                check("stb_held", 32'(s_stb), 32'd1);
                if (i == stall_n - 1) s_stall = 1'b0;
            end
            @(posedge clk); #1;
            check("wait_bus", 32'({s_cyc, s_stb}), 32'd2);
            if (abort) drive_port(p, 1'b0, 1'b0, a);
            if (never_ack) begin
                waits = 1;
                done  = 1'b0;
                for (int i = 0; i < TMO + 8; i++) begin
                    @(posedge clk); #1;
                    if (!s_cyc) begin
                        done = 1'b1;
                        break;
                    end
                    waits++;
                end
                check("tmo_reached", 32'(done), 32'd1);
                check("tmo_cycles", 32'(waits), 32'(TMO));
                check("tmo_err", 32'(err_of(p)), 32'(!abort));
                check("tmo_no_ack", 32'(ack_of(p)), 32'd0);
            end else begin
                for (int i = 0; i < ack_dly; i++) begin
                    @(posedge clk); #1;
                end
                check("still_waiting", 32'({s_cyc, ack_of(p), err_of(p)}), 32'd4);
                s_ack  = 1'b1;
                s_data = w;
                inval  = inval_at_ack;
                @(posedge clk); #1;
                s_ack  = 1'b0;
                s_data = '0;
                inval  = 1'b0;
                check("resp_ack", 32'(ack_of(p)), 32'(!abort));
                check("resp_err", 32'(err_of(p)), 32'd0);
                check("resp_cyc_drop", 32'(s_cyc), 32'd0);
                if (!abort) check("resp_data", data_of(p), w);
                mdl_valid = !inval_at_ack;
                mdl_tag   = a;
                mdl_data  = w;
            end
        end
        check("one_pulse", 32'({ack_of(1 - p), err_of(1 - p)}), 32'd0);
        drive_port(p, 1'b0, 1'b0, a);
        @(posedge clk); #1;
        check("quiet", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
    endtask

    // Both ports request in the same cycle; the model picks the winner.
    task automatic dual(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input int st, input int dly);
        int win;
        drive_port(0, 1'b1, 1'b1, a0);
        drive_port(1, 1'b1, 1'b1, a1);
        win = (last_port == 0) ? 1 : 0;
        read_txn(win,     (win == 0) ? a0 : a1, st, dly, 1'b0, 1'b0, 1'b0);
        read_txn(1 - win, (win == 0) ? a1 : a0, 0,  dly, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] pool [4];
        int            p;
        pool[0] = 22'h000100; pool[1] = 22'h000204;
        pool[2] = 22'h3FFFFF; pool[3] = 22'h000000;

        // Reset, with port 0 requesting to show stall is held high.
        rst = 1'b0;
        drive_port(0, 1'b1, 1'b1, 22'h000100);
        @(posedge clk); #1;
        check("rst_stall0", 32'(m0_stall), 32'd1);
        check("rst_stall1", 32'(m1_stall), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'({s_cyc, s_stb, s_sel, m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
        check("rst_saddr", 32'(s_addr), 32'd0);
        drive_port(0, 1'b0, 1'b0, 22'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_outs", 32'({s_cyc, m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
        check("post_rst_stalls", 32'({m0_stall, m1_stall}), 32'd3);

        // Basic miss, then hit, then invalidate and miss again.
        flash_mem[22'h000100] = 32'hDEADBEEF;
        read_txn(0, 22'h000100, 0, 5, 1'b0, 1'b0, 1'b0);
        read_txn(0, 22'h000100, 0, 0, 1'b0, 1'b0, 1'b0);
        pulse_inval();
        read_txn(0, 22'h000100, 2, 1, 1'b0, 1'b0, 1'b0);

        // Ack in the same cycle the timeout would fire: ack wins.
        read_txn(0, 22'h0003C4, 0, TMO - 1, 1'b0, 1'b0, 1'b0);

        // Timeout on port 1, then the same address misses.
        read_txn(1, 22'h0002A0, 1, 0, 1'b0, 1'b1, 1'b0);
        read_txn(1, 22'h0002A0, 0, 2, 1'b0, 1'b0, 1'b0);

        // Simultaneous requests twice in a row.
        dual(22'h000010, 22'h000020, 0, 1);
        dual(22'h000030, 22'h000040, 1, 0);

        // Master abort during WAIT; data still cached.
        flash_mem[22'h000155] = 32'h12345678;
        read_txn(0, 22'h000155, 0, 2, 1'b1, 1'b0, 1'b0);
        read_txn(0, 22'h000155, 0, 0, 1'b0, 1'b0, 1'b0);

        // inval coinciding with capture: data returned, nothing cached.
        read_txn(1, 22'h0000AA, 0, 1, 1'b0, 1'b0, 1'b1);
        read_txn(1, 22'h0000AA, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized reads over a small address pool to mix hits and misses.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(3) == 0) begin
                dual(pool[$urandom_range(3)], pool[$urandom_range(3)],
                     int'($urandom_range(2)), int'($urandom_range(3)));
            end else begin
                p = int'($urandom_range(1));
                read_txn(p, pool[$urandom_range(3)], int'($urandom_range(2)),
                         int'($urandom_range(4)), ($urandom_range(7) == 0),
                         ($urandom_range(11) == 0), ($urandom_range(9) == 0));
            end
            if ($urandom_range(4) == 0) pulse_inval();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
